bp_be_pipe_int_pipelined: RTL

Parametrised, multi-stage successor to the backend integer pipe. Computes RV64/RV32 integer ALU results, optionally with word (opw) semantics, and carries them with a destination tag through `latency_p` registered stages. The stages use valid/ready handshaking, bubble collapsing and whole-pipe flush. The block sits in the calculator between dispatch and the writeback/bypass network, so the integer result can be retimed to match the other pipes.

---
 rtl/bp_be_pkg.sv | 24 ++
 rtl/bp_be_int_alu.sv | 72 +++++++
 rtl/bp_be_pipe_int_pipelined.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/bp_be_pkg.sv
// Shared types and constants for the backend integer pipe.
package bp_be_pkg;

   localparam int rv64_word_width_gp = 32;

   typedef enum logic [3:0] {
      e_int_op_add       = 4'd0,
      e_int_op_sub       = 4'd1,
      e_int_op_xor       = 4'd2,
      e_int_op_or        = 4'd3,
      e_int_op_and       = 4'd4,
      e_int_op_sll       = 4'd5,
      e_int_op_srl       = 4'd6,
      e_int_op_sra       = 4'd7,
      e_int_op_pass_src2 = 4'd8,
      e_int_op_eq        = 4'd9,
      e_int_op_ne        = 4'd10,
      e_int_op_slt       = 4'd11,
      e_int_op_sltu      = 4'd12,
      e_int_op_sge       = 4'd13,
      e_int_op_sgeu      = 4'd14
   } bp_be_int_fu_op_e;

endpackage

// File: rtl/bp_be_int_alu.sv
// Combinational RV64/RV32 integer ALU; word ops run on operands moved into the upper half
// so overflow and sign land naturally, then the result is sign-extended back down.
module bp_be_int_alu
   import bp_be_pkg::*;
#(
   parameter int width_p = 64
) (
   input  logic [3:0]         fu_op,
   input  logic               opw_v,
   input  logic [width_p-1:0] src1,
   input  logic [width_p-1:0] src2,
   output logic [width_p-1:0] result
);

   localparam int word_shift_lp = (width_p > rv64_word_width_gp) ? rv64_word_width_gp : 0;

   logic               opw_en;
   logic [width_p-1:0] opa;
   logic [width_p-1:0] opb;
   logic [width_p-1:0] raw;
   logic [5:0]         shamt;
   logic               is_cmp;
   logic               cmp;

   assign opw_en = opw_v && (width_p == 64);

   // Shift amount always comes from the unshifted src2.
   always_comb begin
      opa   = src1;
      opb   = src2;
      shamt = {1'b0, src2[4:0]};
      if (opw_en) begin
         opa = src1 << word_shift_lp;
         opb = src2 << word_shift_lp;
      end else if (width_p == 64) begin
         shamt = src2[5:0];
      end
   end

   always_comb begin
      raw    = '0;
      is_cmp = 1'b0;
      cmp    = 1'b0;
      case (fu_op)
         e_int_op_add:       raw = opa + opb;
         e_int_op_sub:       raw = opa - opb;
         e_int_op_xor:       raw = opa ^ opb;
         e_int_op_or:        raw = opa | opb;
         e_int_op_and:       raw = opa & opb;
         e_int_op_sll:       raw = opa << shamt;
         e_int_op_srl:       raw = opa >> shamt;
         e_int_op_sra:       raw = $signed(opa) >>> shamt;
         e_int_op_pass_src2: raw = opb;
         e_int_op_eq:   begin is_cmp = 1'b1; cmp = (opa == opb); end
         e_int_op_ne:   begin is_cmp = 1'b1; cmp = (opa != opb); end
         e_int_op_slt:  begin is_cmp = 1'b1; cmp = ($signed(opa) < $signed(opb)); end
         e_int_op_sltu: begin is_cmp = 1'b1; cmp = (opa < opb); end
         e_int_op_sge:  begin is_cmp = 1'b1; cmp = ($signed(opa) >= $signed(opb)); end
         e_int_op_sgeu: begin is_cmp = 1'b1; cmp = (opa >= opb); end
         default:            raw = '0;
      endcase
      if (is_cmp) begin
         raw = {{(width_p-1){1'b0}}, cmp};
      end
      if (opw_en && !is_cmp) begin
         result = $signed(raw) >>> word_shift_lp;
      end else begin
         result = raw;
      end
   end

endmodule

// File: rtl/bp_be_pipe_int_pipelined.sv
// Integer pipe: ALU result and tag retimed through latency_p valid/ready stages with bubble collapse.
// Define BP_BE_PIPE_INT_BRANCH_EN to also resolve and carry branch taken / next pc.
module bp_be_pipe_int_pipelined
   import bp_be_pkg::*;
#(
   parameter int width_p     = 64,
   parameter int latency_p   = 2,
   parameter int tag_width_p = 5
) (
   input  logic                   clk_i,
   input  logic                   reset_n_i,
   input  logic                   v_i,
   output logic                   ready_o,
   input  logic [3:0]             fu_op_i,
   input  logic                   opw_v_i,
   input  logic [width_p-1:0]     src1_i,
   input  logic [width_p-1:0]     src2_i,
   input  logic [tag_width_p-1:0] tag_i,
   input  logic                   flush_i,
   output logic                   v_o,
   input  logic                   yumi_i,
   output logic [width_p-1:0]     data_o,
   output logic [tag_width_p-1:0] tag_o
`ifdef BP_BE_PIPE_INT_BRANCH_EN
   ,
   input  logic                   br_v_i,
   input  logic [width_p-1:0]     pc_i,
   input  logic [width_p-1:0]     imm_i,
   output logic                   taken_o,
   output logic [width_p-1:0]     npc_o
`endif
);

   localparam int last_lp = latency_p - 1;

   logic [width_p-1:0]     alu_result;
   logic                   accept;
   logic                   slot_open;
   logic [latency_p-1:0]   stage_v;
   logic [latency_p-1:0]   adv;
   logic [width_p-1:0]     stage_data [latency_p];
   logic [tag_width_p-1:0] stage_tag  [latency_p];
`ifdef BP_BE_PIPE_INT_BRANCH_EN
   logic                   alu_taken;
   logic [width_p-1:0]     alu_npc;
   logic [latency_p-1:0]   stage_taken;
   logic [width_p-1:0]     stage_npc [latency_p];

   assign alu_taken = br_v_i & alu_result[0];
   assign alu_npc   = alu_taken ? (pc_i + imm_i) : (pc_i + width_p'(4));
`endif

   bp_be_int_alu #(.width_p(width_p)) alu (
      .fu_op  (fu_op_i),
      .opw_v  (opw_v_i),
      .src1   (src1_i),
      .src2   (src2_i),
      .result (alu_result)
   );

   // Walk from the output back to stage 1: a stage moves if the slot ahead is empty or vacating.
   always_comb begin
      slot_open = yumi_i;
      adv       = '0;
      for (int k = last_lp; k >= 0; k--) begin
         adv[k]    = stage_v[k] & slot_open;
         slot_open = ~stage_v[k] | adv[k];
      end
   end

   assign ready_o = slot_open;
   assign accept  = v_i & ready_o & ~flush_i;

   for (genvar k = 0; k < latency_p; k++) begin : g_stage
      logic                   fill;
      logic                   v_r;
      logic [width_p-1:0]     data_in;
      logic [width_p-1:0]     data_r;
      logic [tag_width_p-1:0] tag_in;
      logic [tag_width_p-1:0] tag_r;
`ifdef BP_BE_PIPE_INT_BRANCH_EN
      logic                   taken_in;
      logic                   taken_r;
      logic [width_p-1:0]     npc_in;
      logic [width_p-1:0]     npc_r;
`endif

      if (k == 0) begin : g_head
         assign fill     = accept;
         assign data_in  = alu_result;
         assign tag_in   = tag_i;
`ifdef BP_BE_PIPE_INT_BRANCH_EN
         assign taken_in = alu_taken;
         assign npc_in   = alu_npc;
`endif
      end else begin : g_tail
         assign fill     = adv[k-1];
         assign data_in  = stage_data[k-1];
         assign tag_in   = stage_tag[k-1];
`ifdef BP_BE_PIPE_INT_BRANCH_EN
         assign taken_in = stage_taken[k-1];
         assign npc_in   = stage_npc[k-1];
`endif
      end

      // Flush wins over both refill and drain.
      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) begin
            v_r <= 1'b0;
         end else if (flush_i) begin
            v_r <= 1'b0;
         end else if (fill) begin
            v_r <= 1'b1;
         end else if (adv[k]) begin
            v_r <= 1'b0;
         end
      end

      always_ff @(posedge clk_i) begin
         if (fill) begin
            data_r  <= data_in;
            tag_r   <= tag_in;
`ifdef BP_BE_PIPE_INT_BRANCH_EN
            taken_r <= taken_in;
            npc_r   <= npc_in;
`endif
         end
      end

      assign stage_v[k]     = v_r;
      assign stage_data[k]  = data_r;
      assign stage_tag[k]   = tag_r;
`ifdef BP_BE_PIPE_INT_BRANCH_EN
      assign stage_taken[k] = taken_r;
      assign stage_npc[k]   = npc_r;
`endif
   end

   assign v_o    = stage_v[last_lp];
   assign data_o = stage_data[last_lp];
   assign tag_o  = stage_tag[last_lp];
`ifdef BP_BE_PIPE_INT_BRANCH_EN
   assign taken_o = stage_taken[last_lp];
   assign npc_o   = stage_npc[last_lp];
`endif

endmodule
